mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, memory address width in bits.
REQ-002 SHALL have parameter DW, default 32, data width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port m0_req  input  1  instruction-fetch read request.
REQ-006 SHALL have port m0_addr  input  AW  fetch address.
REQ-007 SHALL have port m0_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port m0_rvalid  output  1  fetch read data valid.
REQ-009 SHALL have port m0_rdata  output  DW  fetch read data.
REQ-010 SHALL have port m1_req  input  1  load/store request.
REQ-011 SHALL have port m1_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port m1_addr  input  AW  load/store address.
REQ-013 SHALL have port m1_wdata  input  DW  store data.
REQ-014 SHALL have port m1_be  input  DW/8  store byte enables.
REQ-015 SHALL have port m1_gnt  output  1  load/store request accepted this cycle.
REQ-016 SHALL have port m1_rvalid  output  1  load data valid.
REQ-017 SHALL have port m1_rdata  output  DW  load data.
REQ-018 SHALL have ports mem_ce/mem_we (1), mem_addr (AW), mem_wdata (DW), mem_be (DW/8)  output  request to the single-port memory.
REQ-019 SHALL have port mem_rdata  input  DW  memory read data, valid exactly one cycle after mem_ce with mem_we=0.
REQ-020 SHALL have port conflict_cnt  output  16  count of cycles in which both requesters asked.

Function
REQ-021 SHALL grant combinationally: at most one of m0_gnt/m1_gnt high per cycle; gnt high only when corresponding req high.
REQ-022 SHALL, with only one req high, grant that requester.
REQ-023 SHALL, with both req high, grant the requester not granted most recently (round-robin via 1-bit last_owner register).
REQ-024 SHALL update last_owner on every grant; unchanged in cycles without grant.
REQ-025 SHALL drive mem_ce = m0_gnt | m1_gnt; mem_addr/mem_we/mem_wdata/mem_be from granted requester; m0 grant forces mem_we=0, mem_be=all ones.
REQ-026 SHALL, for every granted read, register a 1-bit response tag plus valid; next cycle assert owner's rvalid for exactly one cycle with rdata = mem_rdata.
REQ-027 SHALL NOT assert any rvalid for a granted store (store completes on grant cycle).
REQ-028 SHALL support back-to-back grants every cycle; response of grant N and grant of N+1 coincide without stall.
REQ-029 SHALL keep non-owner rdata at 0 and rvalid low.
REQ-030 SHALL require requesters hold req and payload stable until gnt; arbiter does not latch ungranted requests.
REQ-031 SHALL increment conflict_cnt each cycle m0_req & m1_req; saturate at 16'hFFFF, no wrap.
REQ-032 SHALL treat req changes mid-cycle purely combinationally; no grant registered.

Reset
REQ-033 SHALL, on rst_n low, immediately clear: response valid, tag, conflict_cnt=0, last_owner=m0 (so m1 wins first conflict).
REQ-034 SHALL hold m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0 during reset; gnt/mem outputs follow REQ-021..025 combinationally only after rst_n high (forced 0 while rst_n low).
REQ-035 SHALL drop an in-flight read response when reset asserts mid-operation; no rvalid after reset release without new grant.

Verification
REQ-036 Only m0_req, addr 0x0000_0010, mem_rdata next cycle 0x0000_0093 -> m0_gnt same cycle, m0_rvalid one cycle later, m0_rdata 0x0000_0093.
REQ-037 Both req held 4 cycles from reset -> grants m1,m0,m1,m0; conflict_cnt=4.
REQ-038 m1 store addr 0x100, wdata 0xDEADBEEF, be 4'b0011 -> mem_ce=1, mem_we=1, mem_be=4'b0011, no rvalid any cycle.
REQ-039 m0 read granted, next cycle m1 load granted -> m0_rvalid and m1_gnt same cycle; m1_rvalid following cycle with correct data.
REQ-040 Read granted, rst_n pulsed low before next edge -> no rvalid after release; conflict_cnt=0, next conflict grants m1.
REQ-041 Both req held 70000 cycles -> conflict_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-master arbiter in front of a single-port synchronous memory.
//   m0 : instruction fetch, read-only
//   m1 : load/store
// Grants are combinational. Both requesting resolves round-robin on a 1-bit
// last_owner register. A granted read is tagged with its owner, and the memory
// data returned on the next cycle is steered to that owner's rdata/rvalid.
// Ungranted requests are not stored: a requester holds req and payload until
// it sees its gnt.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   m0_req/m0_addr              fetch request
//   m0_gnt/m0_rvalid/m0_rdata   fetch accept and read response
//   m1_req/m1_we/m1_addr/
//   m1_wdata/m1_be              load/store request
//   m1_gnt/m1_rvalid/m1_rdata   load/store accept and load response
//   mem_ce/mem_we/mem_addr/
//   mem_wdata/mem_be            request to the memory
//   mem_rdata                   memory read data, one cycle after a read
//   conflict_cnt                saturating count of cycles with both req high
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,

  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,

  output logic [15:0]     conflict_cnt
);

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  owner_e last_owner;
  owner_e resp_tag;
  logic   resp_valid;
  logic   both_req;
  logic   read_grant;

  assign both_req = m0_req & m1_req;

  // Grant decision. Both grants are held low while reset is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (both_req) begin
        // Round-robin: the requester not served most recently wins.
        if (last_owner == OWNER_M0) m1_gnt = 1'b1;
        else                        m0_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Memory request mux. Fetches are always full-word reads.
  always_comb begin
    mem_ce    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_be;
    end else if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_be    = '1;
    end
  end

  // Stores finish on their grant cycle, so only reads create a response.
  assign read_grant = m0_gnt | (m1_gnt & ~m1_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset to m0 so that m1 wins the first conflict.
      last_owner   <= OWNER_M0;
      resp_valid   <= 1'b0;
      resp_tag     <= OWNER_M0;
      conflict_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (m0_gnt)      last_owner <= OWNER_M0;
      else if (m1_gnt) last_owner <= OWNER_M1;

      resp_valid <= read_grant;
      resp_tag   <= m1_gnt ? OWNER_M1 : OWNER_M0;

      if (both_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // Steer the returning data to its owner; the other side stays at zero.
  assign m0_rvalid = resp_valid && (resp_tag == OWNER_M0);
  assign m1_rvalid = resp_valid && (resp_tag == OWNER_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_req;
  logic [AW-1:0]   m0_addr;
  logic            m0_gnt, m0_rvalid;
  logic [DW-1:0]   m0_rdata;
  logic            m1_req, m1_we;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_be;
  logic            m1_gnt, m1_rvalid;
  logic [DW-1:0]   m1_rdata;
  logic            mem_ce, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;
  logic [15:0]     conflict_cnt;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-only memory contents used by the directed vectors.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0000_0093;
      32'h0000_0020: return 32'h1111_2222;
      32'h0000_0104: return 32'hCAFE_F00D;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Garbage when not reading, so unmasked rdata would show up.
  always @(posedge clk)
    mem_rdata <= (mem_ce && !mem_we) ? mem_read(mem_addr) : 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        tag;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;

  task automatic expect_resp(input logic tag, input logic [31:0] data);
    resp_t r;
    r.tag  = tag;
    r.data = data;
    r.cyc  = cyc + 1;
    exp_q.push_back(r);
  endtask

  // Monitor: pops an expected response whenever the DUT presents one.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rvalid_owner", {62'd0, m1_rvalid, m0_rvalid}, mon_e.tag ? 64'd2 : 64'd1);
        check("rdata", mon_e.tag ? m1_rdata : m0_rdata, {32'd0, mon_e.data});
        check("other_rdata", mon_e.tag ? m0_rdata : m1_rdata, 64'd0);
        check("resp_cycle", cyc, mon_e.cyc);
      end
    end else begin
      check("idle_rdata", {m0_rdata, m1_rdata}, 64'd0);
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        check("missing_rvalid", 64'd0, 64'd1);
      end
    end
  end

  task automatic idle();
    m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic [31:0] a);
    m0_req = 1'b1; m0_addr = a;
  endtask

  task automatic drive_m1(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_be = be;
  endtask

  logic nxt_m1;

  initial begin
    idle();
    rst_n = 1'b0;

    // Reset: requests present but everything forced quiet.
    repeat (2) @(posedge clk);
    #1;
    drive_m0(32'h10);
    drive_m1(1'b0, 32'h104, 32'h0, 4'h0);
    #2;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    next();
    check("rst_cnt", conflict_cnt, 0);
    idle();
    rst_n = 1'b1;

    // Single fetch read.
    next();
    drive_m0(32'h10);
    #2;
    check("fetch_m0_gnt", m0_gnt, 1);
    check("fetch_m1_gnt", m1_gnt, 0);
    check("fetch_mem_ce", mem_ce, 1);
    check("fetch_mem_we", mem_we, 0);
    check("fetch_mem_addr", mem_addr, 32'h10);
    check("fetch_mem_be", mem_be, 4'hF);
    expect_resp(1'b0, 32'h0000_0093);
    next();
    idle();

    // Store: no response may follow.
    next();
    drive_m1(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    #2;
    check("store_m1_gnt", m1_gnt, 1);
    check("store_m0_gnt", m0_gnt, 0);
    check("store_mem_ce", mem_ce, 1);
    check("store_mem_we", mem_we, 1);
    check("store_mem_addr", mem_addr, 32'h100);
    check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store_mem_be", mem_be, 4'b0011);
    next();
    idle();
    next();

    // Fetch then load back-to-back.
    drive_m0(32'h20);
    #2;
    check("b2b_m0_gnt", m0_gnt, 1);
    expect_resp(1'b0, 32'h1111_2222);
    next();
    idle();
    drive_m1(1'b0, 32'h104, 32'h0, 4'hF);
    #2;
    check("b2b_m1_gnt", m1_gnt, 1);
    check("b2b_m0_rvalid", m0_rvalid, 1);
    expect_resp(1'b1, 32'hCAFE_F00D);
    next();
    idle();
    next();

    // Round-robin from reset: m1, m0, m1, m0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next();
    drive_m0(32'h10);
    drive_m1(1'b0, 32'h104, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      #2;
      check("rr_m1_gnt", m1_gnt, (k % 2 == 0) ? 1 : 0);
      check("rr_m0_gnt", m0_gnt, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) expect_resp(1'b1, 32'hCAFE_F00D);
      else            expect_resp(1'b0, 32'h0000_0093);
      next();
    end
    idle();
    #2;
    check("rr_conflict_cnt", conflict_cnt, 4);
    check("rr_idle_ce", mem_ce, 0);
    next();

    // Leave last_owner at m1 so the post-reset conflict is meaningful.
    drive_m1(1'b0, 32'h104, 32'h0, 4'hF);
    #2;
    expect_resp(1'b1, 32'hCAFE_F00D);
    next();
    idle();
    next();

    // Reset pulse inside a granting cycle.
    drive_m0(32'h10);
    #2;
    check("rpulse_gnt_before", m0_gnt, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rpulse_gnt_forced", m0_gnt, 0);
    check("rpulse_ce_forced", mem_ce, 0);
    idle();
    #1;
    rst_n = 1'b1;
    next();
    check("rpulse_cnt", conflict_cnt, 0);

    // Reset while a read response is in flight.
    drive_m0(32'h10);
    #2;
    check("inflight_gnt", m0_gnt, 1);
    next();
    rst_n = 1'b0;
    idle();
    #1;
    check("inflight_rvalid", {m0_rvalid, m1_rvalid}, 0);
    rst_n = 1'b1;
    next();
    next();

    // First conflict after reset goes to m1.
    drive_m0(32'h10);
    drive_m1(1'b0, 32'h104, 32'h0, 4'hF);
    #2;
    check("post_rst_m1_gnt", m1_gnt, 1);
    check("post_rst_m0_gnt", m0_gnt, 0);
    expect_resp(1'b1, 32'hCAFE_F00D);
    next();
    idle();
    #2;
    check("post_rst_cnt", conflict_cnt, 1);
    next();

    // Saturation: m0 fetches, m1 stores, both held.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next();
    drive_m0(32'h10);
    drive_m1(1'b1, 32'h200, 32'h1234_5678, 4'hF);
    nxt_m1 = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      #2;
      if (i == 65534) check("sat_cnt_fffe", conflict_cnt, 16'hFFFE);
      if (i == 65535 || i == 69999) check("sat_cnt_ffff", conflict_cnt, 16'hFFFF);
      check("sat_m1_gnt", m1_gnt, nxt_m1);
      if (!nxt_m1) expect_resp(1'b0, 32'h0000_0093);
      nxt_m1 = ~nxt_m1;
      next();
    end
    idle();
    next();
    next();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
